// File: rtl/codec_init_pkg.sv
// Shared types and the default register table for the codec init sequencer.
package codec_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6
  } state_e;

  // One register write: 7-bit codec register address, 9-bit value.
  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] val;
  } entry_t;

  localparam int DEFAULT_LEN = 5;

  // Power-up register program, written in this order before the settle delay.
  localparam entry_t DEFAULT_TABLE [DEFAULT_LEN] = '{
    '{addr: 7'd6, val: 9'h000},
    '{addr: 7'd0, val: 9'h017},
    '{addr: 7'd1, val: 9'h017},
    '{addr: 7'd4, val: 9'h002},
    '{addr: 7'd7, val: 9'h04A}
  };

endpackage

// File: rtl/codec_init_rom.sv
// Combinational table lookup; indices outside the table return an all-zero entry.
import codec_init_pkg::*;

module codec_init_rom #(
  parameter int NUM_WRITES = 5
) (
  input  logic [5:0] idx,
  output entry_t     entry
);

  localparam logic [5:0] LIMIT   = 6'(NUM_WRITES);
  localparam logic [5:0] TBL_LEN = 6'(DEFAULT_LEN);

  // Select the table entry, zero when idx is beyond the configured or stored table.
  always_comb begin
    entry = '0;
    if (idx < LIMIT && idx < TBL_LEN) begin
      entry = DEFAULT_TABLE[idx[2:0]];
    end
  end

endmodule

// File: rtl/codec_init_seq.sv
// Codec register-write sequencer: walks the table through the I2C master with
// retries, waits a settle delay, writes the activation register, then enables I2S.
//
// Handshake: a request is presented by holding i2c_register/i2c_din stable with
// i2c_enable high until the master pulses i2c_rdy (done) or i2c_err (failed);
// err wins when both are seen together. i2c_enable is dropped on the edge that
// samples the strobe and is low for at least one cycle before the next request.
import codec_init_pkg::*;

module codec_init_seq #(
  parameter int         NUM_WRITES   = 5,
  parameter int         DELAY_CYCLES = 1048575,
  parameter int         MAX_RETRIES  = 3,
  parameter int         RETRY_GAP    = 255,
  parameter logic [6:0] ACT_REG      = 7'd9,
  parameter logic [8:0] ACT_VAL      = 9'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [6:0] i2c_register,
  output logic [8:0] i2c_din,
  output logic       i2c_enable,
  output logic       i2c_rw,
  input  logic       i2c_rdy,
  input  logic       i2c_err,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] step_idx,
  output logic [3:0] retry_cnt,
  output logic       snd_enable,
  output logic       mute_n
);

  localparam int DW = $clog2(DELAY_CYCLES) + 1;
  localparam int GW = $clog2(RETRY_GAP) + 1;

  localparam logic [DW-1:0] DELAY_LOAD  = DW'(DELAY_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD    = GW'(RETRY_GAP);
  localparam logic [5:0]    LAST_TABLE  = 6'(NUM_WRITES - 1);
  localparam logic [5:0]    ACT_IDX     = 6'(NUM_WRITES);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_GAP   = ST_GAP;
  localparam logic [2:0] S_PAUSE = ST_PAUSE;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [2:0] S_FAIL  = ST_FAIL;

  logic [2:0]    state;
  logic [DW-1:0] delay_cnt;
  logic [GW-1:0] gap_cnt;
  entry_t        rom_entry;

  codec_init_rom #(.NUM_WRITES(NUM_WRITES)) u_rom (
    .idx   (step_idx),
    .entry (rom_entry)
  );

  assign i2c_rw = 1'b0;

  // Sequencer FSM. GAP and PAUSE each last exactly their load value in cycles:
  // the counter leaves on the cycle it reads 1, so ISSUE follows immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      i2c_register <= '0;
      i2c_din      <= '0;
      i2c_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      step_idx     <= '0;
      retry_cnt    <= '0;
      snd_enable   <= 1'b0;
      mute_n       <= 1'b0;
      delay_cnt    <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            step_idx   <= '0;
            retry_cnt  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            snd_enable <= 1'b0;
            mute_n     <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (step_idx == ACT_IDX) begin
            i2c_register <= ACT_REG;
            i2c_din      <= ACT_VAL;
          end else begin
            i2c_register <= rom_entry.addr;
            i2c_din      <= rom_entry.val;
          end
          i2c_enable <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (i2c_err) begin
            i2c_enable <= 1'b0;
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + 4'd1;
              gap_cnt   <= GAP_LOAD;
              state     <= S_GAP;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_FAIL;
            end
          end else if (i2c_rdy) begin
            i2c_enable <= 1'b0;
            retry_cnt  <= '0;
            if (step_idx == LAST_TABLE) begin
              step_idx  <= ACT_IDX;
              delay_cnt <= DELAY_LOAD;
              state     <= S_PAUSE;
            end else if (step_idx == ACT_IDX) begin
              done       <= 1'b1;
              busy       <= 1'b0;
              snd_enable <= 1'b1;
              mute_n     <= 1'b1;
              state      <= S_DONE;
            end else begin
              step_idx <= step_idx + 6'd1;
              state    <= S_ISSUE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt <= GW'(1)) begin
            gap_cnt <= '0;
            state   <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        S_PAUSE: begin
          if (delay_cnt <= DW'(1)) begin
            delay_cnt <= '0;
            state     <= S_ISSUE;
          end else begin
            delay_cnt <= delay_cnt - DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: an I2C master model with scripted/random failures,
// a request-level reference model checked every cycle, and directed scenarios.
module tb_codec_init_seq;

  localparam int NW  = 5;
  localparam int DLY = 20;
  localparam int MR  = 3;
  localparam int RG  = 4;

  localparam int POST_NONE  = 0;
  localparam int POST_NEXT  = 1;
  localparam int POST_RETRY = 2;
  localparam int POST_DONE  = 3;
  localparam int POST_FAIL  = 4;

  localparam int RES_DONE = 1;
  localparam int RES_FAIL = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       i2c_rdy = 1'b0;
  logic       i2c_err = 1'b0;
  logic [6:0] i2c_register;
  logic [8:0] i2c_din;
  logic       i2c_enable;
  logic       i2c_rw;
  logic       busy;
  logic       done;
  logic       error;
  logic [5:0] step_idx;
  logic [3:0] retry_cnt;
  logic       snd_enable;
  logic       mute_n;

  int checks = 0;
  int errors = 0;

  // driver-owned scenario controls
  int run_id    = 0;
  int lat       = 3;
  int both_step = -1;
  int err_plan [0:NW];

  // model-owned state
  int         seen_id  = 0;
  int         res_id   = 0;
  int         res_code = 0;
  bit         m_active = 1'b0;
  int         cur_step;
  int         cur_try;
  int         exp_gap;
  int         low_cnt;
  int         resp_cd;
  int         post;
  int         post_now;
  bit         prev_en  = 1'b0;
  bit         first_req;
  logic [15:0] hold_pair;
  logic [15:0] exp_q [$];
  int          gap_q [$];

  // clock
  always #5 clk = ~clk;

  codec_init_seq #(
    .NUM_WRITES   (NW),
    .DELAY_CYCLES (DLY),
    .MAX_RETRIES  (MR),
    .RETRY_GAP    (RG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .i2c_register (i2c_register),
    .i2c_din      (i2c_din),
    .i2c_enable   (i2c_enable),
    .i2c_rw       (i2c_rw),
    .i2c_rdy      (i2c_rdy),
    .i2c_err      (i2c_err),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .step_idx     (step_idx),
    .retry_cnt    (retry_cnt),
    .snd_enable   (snd_enable),
    .mute_n       (mute_n)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {register, value} the codec must receive for write number s.
  function automatic logic [15:0] exp_entry(input int s);
    case (s)
      0:       return {7'd6, 9'h000};
      1:       return {7'd0, 9'h017};
      2:       return {7'd1, 9'h017};
      3:       return {7'd4, 9'h002};
      4:       return {7'd7, 9'h04A};
      default: return {7'd9, 9'h001};
    endcase
  endfunction

  // I2C master model plus request-level reference model, evaluated every negedge.
  always @(negedge clk) begin
    i2c_rdy = 1'b0;
    i2c_err = 1'b0;
    if (reset) begin
      m_active = 1'b0;
    end else if (run_id != seen_id) begin
      seen_id   = run_id;
      m_active  = 1'b1;
      cur_step  = 0;
      cur_try   = 0;
      exp_gap   = 1;
      low_cnt   = 0;
      resp_cd   = 0;
      post      = POST_NONE;
      first_req = 1'b1;
      exp_q.delete();
      gap_q.delete();
    end
    if (m_active) begin
      post_now = post;
      post     = POST_NONE;
      check("rw_zero", 32'(i2c_rw), 0);
      if (post_now == POST_DONE) begin
        check("done_set", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_snd", 32'(snd_enable), 1);
        check("done_mute", 32'(mute_n), 1);
        check("done_error", 32'(error), 0);
        check("done_enable", 32'(i2c_enable), 0);
        check("done_retry", 32'(retry_cnt), 0);
        m_active = 1'b0;
        res_code = RES_DONE;
        res_id   = seen_id;
      end else if (post_now == POST_FAIL) begin
        check("fail_error", 32'(error), 1);
        check("fail_busy", 32'(busy), 0);
        check("fail_done", 32'(done), 0);
        check("fail_snd", 32'(snd_enable), 0);
        check("fail_mute", 32'(mute_n), 0);
        check("fail_enable", 32'(i2c_enable), 0);
        m_active = 1'b0;
        res_code = RES_FAIL;
        res_id   = seen_id;
      end else begin
        if (post_now != POST_NONE) begin
          check("strobe_enable_drop", 32'(i2c_enable), 0);
          check("strobe_retry_cnt", 32'(retry_cnt), cur_try);
          check("strobe_step_idx", 32'(step_idx), cur_step);
        end
        check("run_busy", 32'(busy), 1);
        check("run_done", 32'(done), 0);
        check("run_error", 32'(error), 0);
        check("run_snd", 32'(snd_enable), 0);
        check("run_mute", 32'(mute_n), 0);
        if (i2c_enable && !prev_en) begin
          hold_pair = {i2c_register, i2c_din};
          exp_q.push_back(hold_pair);
          check("req_pair", 32'(hold_pair), 32'(exp_entry(cur_step)));
          check("req_step_idx", 32'(step_idx), cur_step);
          check("req_retry_cnt", 32'(retry_cnt), cur_try);
          if (!first_req) begin
            gap_q.push_back(low_cnt);
            check("req_low_gap", low_cnt, exp_gap);
          end
          first_req = 1'b0;
          low_cnt   = 0;
          resp_cd   = lat;
        end else if (i2c_enable) begin
          check("req_stable", 32'({i2c_register, i2c_din}), 32'(hold_pair));
        end
        if (i2c_enable) begin
          if (resp_cd <= 1) begin
            if (cur_try < err_plan[cur_step]) begin
              i2c_err = 1'b1;
              i2c_rdy = (cur_step == both_step && cur_try == 0) ? 1'b1 : 1'b0;
              if (cur_try < MR) begin
                cur_try++;
                exp_gap = RG + 1;
                post    = POST_RETRY;
              end else begin
                post = POST_FAIL;
              end
            end else begin
              i2c_rdy = 1'b1;
              if (cur_step == NW) begin
                post = POST_DONE;
              end else begin
                exp_gap  = (cur_step == NW - 1) ? DLY + 1 : 1;
                cur_step++;
                cur_try  = 0;
                post     = POST_NEXT;
              end
            end
          end else begin
            resp_cd--;
          end
        end else begin
          low_cnt++;
        end
      end
    end
    prev_en = i2c_enable;
  end

  task automatic clear_plan();
    for (int s = 0; s <= NW; s++) err_plan[s] = 0;
    both_step = -1;
    lat       = 3;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_res);
    int c = 0;
    while (res_id != run_id && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({name, "_finished"}, 32'(res_id == run_id), 1);
    if (res_id == run_id) check({name, "_result"}, res_code, exp_res);
  endtask

  task automatic run_seq(input string name, input int exp_res);
    pulse_start();
    run_id++;
    wait_result(name, exp_res);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_register"}, 32'(i2c_register), 0);
    check({name, "_din"}, 32'(i2c_din), 0);
    check({name, "_enable"}, 32'(i2c_enable), 0);
    check({name, "_rw"}, 32'(i2c_rw), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_error"}, 32'(error), 0);
    check({name, "_step_idx"}, 32'(step_idx), 0);
    check({name, "_retry_cnt"}, 32'(retry_cnt), 0);
    check({name, "_snd"}, 32'(snd_enable), 0);
    check({name, "_mute"}, 32'(mute_n), 0);
  endtask

  // Driver: directed scenarios, then randomized runs, then the summary.
  initial begin
    int c;
    int exp_res;
    int r;
    reset = 1'b1;
    start = 1'b0;
    clear_plan();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // clean sequence, latency 3
    run_seq("clean", RES_DONE);
    check("clean_req_count", exp_q.size(), 6);
    if (exp_q.size() == 6) begin
      check("clean_first", 32'(exp_q[0]), 32'h0C00);
      check("clean_last_table", 32'(exp_q[4]), 32'h0E4A);
      check("clean_activation", 32'(exp_q[5]), 32'h1201);
      check("clean_gap_normal", gap_q[0], 1);
      check("clean_gap_pause", gap_q[4], 21);
    end

    // one err on step 2
    clear_plan();
    err_plan[2] = 1;
    run_seq("retry_once", RES_DONE);
    check("retry_req_count", exp_q.size(), 7);
    if (exp_q.size() == 7) begin
      check("retry_first_try", 32'(exp_q[2]), 32'h0217);
      check("retry_reissue", 32'(exp_q[3]), 32'h0217);
      check("retry_gap", gap_q[2], 5);
    end

    // persistent err on step 0
    clear_plan();
    err_plan[0] = 99;
    run_seq("persist_err", RES_FAIL);
    check("persist_attempts", exp_q.size(), 4);
    @(negedge clk);
    check("persist_error_held", 32'(error), 1);
    check("persist_snd", 32'(snd_enable), 0);
    clear_plan();
    run_seq("after_fail", RES_DONE);

    // rdy and err together on step 1
    clear_plan();
    err_plan[1] = 1;
    both_step   = 1;
    run_seq("rdy_err_same", RES_DONE);
    check("both_req_count", exp_q.size(), 7);
    if (exp_q.size() == 7) begin
      check("both_first", 32'(exp_q[1]), 32'h0017);
      check("both_reissue", 32'(exp_q[2]), 32'h0017);
    end

    // reset during WAIT of step 3
    clear_plan();
    pulse_start();
    run_id++;
    c = 0;
    while (!(step_idx == 6'd3 && i2c_enable) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("reach_step3_wait", 32'(c < 1000), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    #1 reset = 1'b0;
    run_seq("after_reset", RES_DONE);

    // start while busy is ignored
    clear_plan();
    pulse_start();
    run_id++;
    c = 0;
    while (!(step_idx == 6'd5 && busy && !i2c_enable) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("reach_pause", 32'(c < 1000), 1);
    pulse_start();
    @(negedge clk);
    check("busy_start_step", 32'(step_idx), 5);
    check("busy_start_busy", 32'(busy), 1);
    wait_result("busy_start", RES_DONE);

    // start in DONE reruns from entry 0
    run_seq("restart_done", RES_DONE);
    if (exp_q.size() > 0) check("restart_first", 32'(exp_q[0]), 32'h0C00);

    // randomized failures and master latency
    for (int n = 0; n < 12; n++) begin
      clear_plan();
      lat     = $urandom_range(1, 6);
      exp_res = RES_DONE;
      for (int s = 0; s <= NW; s++) begin
        r = $urandom_range(0, 11);
        if (r == 0) err_plan[s] = MR + 1;
        else if (r < 4) err_plan[s] = $urandom_range(1, MR);
        else err_plan[s] = 0;
      end
      for (int s = 0; s <= NW; s++) begin
        if (err_plan[s] > MR) exp_res = RES_FAIL;
      end
      both_step = $urandom_range(0, NW);
      run_seq("random", exp_res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
